game_board_mover: RTL
=====================

# game_board_mover

Sequential, parametrised board-move engine for the 2048 game core. On a start request it captures a full GRID_N×GRID_N board and a move direction, then slides and merges one lane (row or column) per clock. When all lanes are done it presents the new board plus `moved`, `max_tile` and, optionally, `score_delta`. It sits between the input/controller FSM and the board register, replacing the per-row combinational push/merge path with one shared lane unit.

## Interface
Parameters:
- `GRID_N`, default 4: board side length, 2..8.
- `CELL_W`, default 4: bits per cell. Cell holds a log2 tile value; 0 means empty.
- `SCORE_W`, default 20: width of `score_delta`.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: move request; sampled only in IDLE.
- `direction` in 2: 0 left, 1 right, 2 up, 3 down; captured with `start`.
- `board_in` in GRID_N*GRID_N*CELL_W: cell (r,c) at bits [(r*GRID_N+c)*CELL_W +: CELL_W]; row 0 is the top, col 0 is the left.
- `busy` out 1: high from the cycle after `start` is accepted until `done`, inclusive.
- `done` out 1: one-cycle pulse when the result is valid.
- `board_out` out GRID_N*GRID_N*CELL_W: result board, same layout as `board_in`.
- `moved` out 1: 1 if `board_out` differs from the captured board.
- `max_tile` out CELL_W: largest cell value in `board_out`.
- `score_delta` out SCORE_W: present only when `GAME_SCORE_EN` is defined.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN when `start`=1. Capture `board_in` into the working board, latch `direction`, clear lane counter `k`, and clear the accumulators.
  - RUN: each cycle process lane `k`, write it back, then `k`++. After lane GRID_N-1, go to DONE.
  - DONE: assert `done` for one cycle, then return to IDLE.
- Lane extraction, ordered toward the push target:
  - left: row k, c=0..N-1.
  - right: row k, c=N-1..0.
  - up: col k, r=0..N-1.
  - down: col k, r=N-1..0.
- Lane rule:
  - Compact non-zero cells toward index 0.
  - Scan from index 0. Two adjacent equal cells merge into value+1.
  - A cell produced by a merge never merges again in the same move. For example, 2,2,2,2 → 3,3,0,0, not 4,0,0,0.
  - Merge is left-to-right greedy: 1,1,1 → 2,1,0.
  - Saturation: two cells of value 2^CELL_W-1 do not merge.
- `moved` is the OR over lanes of (new lane != old lane).
- `max_tile` is the running max over written lanes, folded in the same cycle.
- `board_out`, `moved`, `max_tile` and `score_delta` update only at the RUN→DONE edge. They hold until the next completed move. Intermediate lanes are never visible.
- `start` while `busy` is ignored; it is not queued.
- `board_in` may change after the capture cycle without effect.
- `rst_n` low mid-move aborts it: FSM to IDLE and all outputs to reset values.

## Timing
- Reset values:
  - `busy`=0, `done`=0, `moved`=0.
  - `board_out`=0, `max_tile`=0, `score_delta`=0.
  - FSM in IDLE, `k`=0.
- `start` sampled high at edge T. Then:
  - `busy`=1 from T+1.
  - Lanes processed on edges T+1..T+GRID_N.
  - `done`=1 and results valid during cycle T+GRID_N+1 (after edge T+GRID_N).
- Latency from `start` to `done` is GRID_N+1 cycles.
- Earliest next accept is the cycle after `done`.
- Sustained throughput is one move per GRID_N+2 cycles.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- `GAME_SCORE_EN` defined:
  - Each merge producing value v adds 2^v to the accumulator, which saturates at 2^SCORE_W-1.
  - The accumulator is cleared on accept and presented on `score_delta` at `done`.
- `GAME_SCORE_EN` undefined:
  - The `score_delta` port and the accumulator logic are removed.
  - All other behaviour is identical.

## Test plan
- GRID_N=4, CELL_W=4. Row 0 = [1,1,1,1], rest 0, direction left → `board_out` row 0 = [2,2,0,0], `moved`=1, `max_tile`=2, `score_delta`=8, `done` exactly 5 cycles after `start`.
- Same board, direction right → row 0 = [0,0,2,2]. Col 0 = [0,0,1,1] top→bottom, direction up → col 0 = [2,0,0,0], `score_delta`=4.
- Board with row 0 = [1,2,3,4] only, direction left → `board_out` equals the input, `moved`=0, `max_tile`=4, `score_delta`=0.
- Row 0 = [15,15,0,0], direction left → unchanged, `moved`=0, `max_tile`=15, no merge.
- `start` pulsed again on cycles 2 and 3 of a move → ignored. Exactly one `done`; `busy` remains high throughout.
- `rst_n` asserted at cycle 2 of RUN → all outputs 0 immediately. After release, a fresh `start` completes normally in 5 cycles.

Source files
------------

// File: rtl/game_board_mover.sv
`default_nettype none
// ============================================================================
// Module   : game_board_mover
// Purpose  : 2048 board-move engine that slides and merges one lane per clock.
//            Define GAME_SCORE_EN to add the score_delta output.
// Revision : 1.0 - initial release
// ============================================================================
module game_board_mover #(
    parameter int GRID_N  = 4,
    parameter int CELL_W  = 4,
    parameter int SCORE_W = 20
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic [1:0]                        direction,
    input  logic [GRID_N*GRID_N*CELL_W-1:0]   board_in,
    output logic                              busy,
    output logic                              done,
    output logic [GRID_N*GRID_N*CELL_W-1:0]   board_out,
    output logic                              moved,
    output logic [CELL_W-1:0]                 max_tile
`ifdef GAME_SCORE_EN
    ,
    output logic [SCORE_W-1:0]                score_delta
`endif
);

    localparam int BW = GRID_N * GRID_N * CELL_W;
    localparam int KW = $clog2(GRID_N);
    localparam logic [CELL_W-1:0] CELL_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [KW-1:0]       k_q, k_d;
    logic [1:0]          dir_q, dir_d;
    logic [BW-1:0]       work_q, work_d;
    logic                moved_acc_q, moved_acc_d;
    logic [CELL_W-1:0]   max_acc_q, max_acc_d;
    logic [BW-1:0]       board_out_q, board_out_d;
    logic                moved_q, moved_d;
    logic [CELL_W-1:0]   max_q, max_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [CELL_W-1:0]   lane_in  [GRID_N];
    logic [CELL_W-1:0]   lane_out [GRID_N];
    logic                lane_diff;
    logic [CELL_W-1:0]   lane_max;

`ifdef GAME_SCORE_EN
    logic [SCORE_W-1:0]  score_acc_q, score_acc_d;
    logic [SCORE_W-1:0]  score_q, score_d;
    logic [SCORE_W-1:0]  score_next;
`else
    if (SCORE_W < 1) begin : g_score_w_unused
    end
`endif

    // Index i of lane 'lane' always runs toward the push target.
    function automatic int cell_pos(input logic [1:0] dir, input int lane, input int idx);
        case (dir)
            2'd0:    return lane * GRID_N + idx;
            2'd1:    return lane * GRID_N + (GRID_N - 1 - idx);
            2'd2:    return idx * GRID_N + lane;
            default: return (GRID_N - 1 - idx) * GRID_N + lane;
        endcase
    endfunction

    always_comb begin
        for (int i = 0; i < GRID_N; i++) begin
            lane_in[i] = work_q[cell_pos(dir_q, int'(k_q), i)*CELL_W +: CELL_W];
        end
    end

    always_comb begin : p_lane
        logic              pend;
        logic [CELL_W-1:0] pv;
        logic [KW-1:0]     o;
`ifdef GAME_SCORE_EN
        logic [CELL_W:0]   mv;
        logic [SCORE_W:0]  tmp;
        score_next = score_acc_q;
        mv         = '0;
        tmp        = '0;
`endif
        pend     = 1'b0;
        pv       = '0;
        o        = '0;
        lane_out = '{default: '0};
        // pv holds the last compacted cell that may still absorb its neighbour.
        for (int i = 0; i < GRID_N; i++) begin
            if (lane_in[i] != '0) begin
                if (pend && (pv == lane_in[i]) && (pv != CELL_MAX)) begin
                    lane_out[o] = pv + 1'b1;
                    o           = o + 1'b1;
                    pend        = 1'b0;
`ifdef GAME_SCORE_EN
                    mv = {1'b0, pv} + 1'b1;
                    if (int'(mv) >= SCORE_W) begin
                        score_next = '1;
                    end else begin
                        tmp = {1'b0, score_next} + ({{SCORE_W{1'b0}}, 1'b1} << mv);
                        score_next = tmp[SCORE_W] ? '1 : tmp[SCORE_W-1:0];
                    end
`endif
                end else begin
                    if (pend) begin
                        lane_out[o] = pv;
                        o           = o + 1'b1;
                    end
                    pv   = lane_in[i];
                    pend = 1'b1;
                end
            end
        end
        if (pend) begin
            lane_out[o] = pv;
        end
    end

    always_comb begin
        lane_diff = 1'b0;
        lane_max  = '0;
        for (int i = 0; i < GRID_N; i++) begin
            if (lane_out[i] != lane_in[i]) begin
                lane_diff = 1'b1;
            end
            if (lane_out[i] > lane_max) begin
                lane_max = lane_out[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        dir_d       = dir_q;
        work_d      = work_q;
        moved_acc_d = moved_acc_q;
        max_acc_d   = max_acc_q;
        board_out_d = board_out_q;
        moved_d     = moved_q;
        max_d       = max_q;
`ifdef GAME_SCORE_EN
        score_acc_d = score_acc_q;
        score_d     = score_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = RUN;
                    work_d      = board_in;
                    dir_d       = direction;
                    k_d         = '0;
                    moved_acc_d = 1'b0;
                    max_acc_d   = '0;
`ifdef GAME_SCORE_EN
                    score_acc_d = '0;
`endif
                end
            end
            RUN: begin
                for (int i = 0; i < GRID_N; i++) begin
                    work_d[cell_pos(dir_q, int'(k_q), i)*CELL_W +: CELL_W] = lane_out[i];
                end
                moved_acc_d = moved_acc_q | lane_diff;
                max_acc_d   = (lane_max > max_acc_q) ? lane_max : max_acc_q;
`ifdef GAME_SCORE_EN
                score_acc_d = score_next;
`endif
                if (k_q == KW'(GRID_N - 1)) begin
                    state_d     = DONE;
                    k_d         = '0;
                    board_out_d = work_d;
                    moved_d     = moved_acc_d;
                    max_d       = max_acc_d;
`ifdef GAME_SCORE_EN
                    score_d     = score_acc_d;
`endif
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            dir_q       <= '0;
            work_q      <= '0;
            moved_acc_q <= 1'b0;
            max_acc_q   <= '0;
            board_out_q <= '0;
            moved_q     <= 1'b0;
            max_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef GAME_SCORE_EN
            score_acc_q <= '0;
            score_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            dir_q       <= dir_d;
            work_q      <= work_d;
            moved_acc_q <= moved_acc_d;
            max_acc_q   <= max_acc_d;
            board_out_q <= board_out_d;
            moved_q     <= moved_d;
            max_q       <= max_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef GAME_SCORE_EN
            score_acc_q <= score_acc_d;
            score_q     <= score_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign board_out = board_out_q;
    assign moved     = moved_q;
    assign max_tile  = max_q;
`ifdef GAME_SCORE_EN
    assign score_delta = score_q;
`endif

endmodule
`default_nettype wire
